// File: rtl/pll_clken_gen.sv
// Purpose: lock-qualified multi-channel clock-enable and divided-toggle generator (refclk domain); optional resync port under PLL_CLKEN_RESYNC_EN.
// Latency: locked rises LOCK_CNT+2 cycles after pll_locked rises and falls 3 cycles after it drops; first strobe N-phase cycles into RUN.
// Backpressure: cfg_ready drops for the one cycle after each config handshake (max one write every two cycles).
module pll_clken_gen #(
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = 16,
   parameter int LOCK_CNT = 1024,
   parameter int DEF_DIV  = 2,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
`ifdef PLL_CLKEN_RESYNC_EN
   input  logic              resync,
`endif
   output logic              cfg_err,
   output logic              locked,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] clk_div
);

   localparam int CNT_W = $clog2(LOCK_CNT);
   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_RUN} state_t;

   state_t            state_q;
   logic              sync1_q, sync2_q;
   logic [CNT_W-1:0]  lock_cnt_q;
   logic              locked_q;
   logic              acc_q, err_q;
   logic [DIV_W-1:0]  sdiv_q [NUM_CH];
   logic [DIV_W-1:0]  sph_q  [NUM_CH];
   logic [DIV_W-1:0]  adiv_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_q  [NUM_CH];
   logic [NUM_CH-1:0] en_q, tog_q;

   logic lk_s, run_enter, run_stay, rs_act, cfg_hs, cfg_bad;

   assign lk_s      = sync2_q;
   assign run_enter = (state_q == ST_QUAL) && lk_s && (lock_cnt_q == CNT_W'(LOCK_CNT - 1));
   assign run_stay  = (state_q == ST_RUN) && lk_s;
`ifdef PLL_CLKEN_RESYNC_EN
   // A lock loss in the same cycle wins over resync.
   assign rs_act    = resync && run_stay;
`else
   assign rs_act    = 1'b0;
`endif
   assign cfg_hs    = cfg_valid && !acc_q;
   assign cfg_bad   = ({1'b0, cfg_ch} >= NUM_CH_L) ||
                      ((cfg_div >= DIV_W'(2)) && (cfg_phase >= cfg_div));

   assign cfg_ready = !acc_q;
   assign cfg_err   = err_q;
   assign locked    = locked_q;
   assign clk_en    = en_q & ~{NUM_CH{rs_act}};
   assign clk_div   = tog_q;

   // Strobe due in the first cycle after a (re)load from the shadow values.
   function automatic logic load_en(input logic [DIV_W-1:0] div, input logic [DIV_W-1:0] ph);
      return (div <= DIV_W'(1)) || (ph == div - DIV_W'(1));
   endfunction

   // Lock synchroniser and IDLE/QUAL/RUN qualification FSM with registered locked.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
         case (state_q)
            ST_IDLE: begin
               if (lk_s) begin
                  lock_cnt_q <= CNT_W'(1);
                  state_q    <= ST_QUAL;
               end
            end
            ST_QUAL: begin
               if (!lk_s) begin
                  lock_cnt_q <= '0;
                  state_q    <= ST_IDLE;
               end else if (run_enter) begin
                  state_q  <= ST_RUN;
                  locked_q <= 1'b1;
               end else begin
                  lock_cnt_q <= lock_cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lk_s) begin
                  lock_cnt_q <= '0;
                  state_q    <= ST_IDLE;
                  locked_q   <= 1'b0;
               end
            end
            default: begin
               lock_cnt_q <= '0;
               state_q    <= ST_IDLE;
               locked_q   <= 1'b0;
            end
         endcase
      end
   end

   // Config handshake: one write per two cycles, invalid writes flagged and dropped, shadows updated.
   always_ff @(posedge refclk) begin
      if (rst) begin
         acc_q <= 1'b0;
         err_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            sdiv_q[i] <= DIV_W'(DEF_DIV);
            sph_q[i]  <= '0;
         end
      end else begin
         acc_q <= cfg_hs;
         err_q <= cfg_hs && cfg_bad;
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_hs && !cfg_bad && (cfg_ch == CH_W'(i))) begin
               sdiv_q[i] <= cfg_div;
               sph_q[i]  <= cfg_phase;
            end
         end
      end
   end

   // Per-channel counters: reload on RUN entry/resync, divide changes only at a wrap so no runt strobes.
   always_ff @(posedge refclk) begin
      if (rst) begin
         en_q  <= '0;
         tog_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            adiv_q[i] <= DIV_W'(DEF_DIV);
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (run_enter || rs_act) begin
               adiv_q[i] <= sdiv_q[i];
               cnt_q[i]  <= sph_q[i];
               tog_q[i]  <= 1'b0;
               en_q[i]   <= load_en(sdiv_q[i], sph_q[i]);
            end else if (run_stay) begin
               if (en_q[i]) begin
                  adiv_q[i] <= sdiv_q[i];
                  cnt_q[i]  <= '0;
                  tog_q[i]  <= !tog_q[i];
                  en_q[i]   <= (sdiv_q[i] <= DIV_W'(1));
               end else begin
                  cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
                  en_q[i]   <= ((cnt_q[i] + DIV_W'(1)) == (adiv_q[i] - DIV_W'(1)));
               end
            end else begin
               en_q[i]  <= 1'b0;
               tog_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Bench for pll_clken_gen: directed lock/config/divide scenarios then randomized traffic,
// every cycle compared against a pulse-countdown reference model.
// Inputs are changed 1 time unit after each rising edge; outputs are sampled there too.
module tb_pll_clken_gen;
   localparam int NCH = 5;
   localparam int DW  = 8;
   localparam int LC  = 16;
   localparam int DD  = 2;

   logic            refclk = 1'b0;
   logic            rst, pll_locked, cfg_valid;
   logic            cfg_ready, cfg_err, locked;
   logic [2:0]      cfg_ch;
   logic [DW-1:0]   cfg_div, cfg_phase;
   logic [NCH-1:0]  clk_en, clk_div;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_en1 = -1;
   int gap_min = 1000;
   int gap_last = 0;

   always #5 refclk = ~refclk;

   pll_clken_gen #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CNT(LC), .DEF_DIV(DD)) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase),
`ifdef PLL_CLKEN_RESYNC_EN
      .resync(1'b0),
`endif
      .cfg_err(cfg_err), .locked(locked), .clk_en(clk_en), .clk_div(clk_div)
   );

   // Reference model: lock = length of the delayed high run of the pin; each channel counts
   // down the cycles left to its next strobe.
   bit m_p1, m_p2, m_locked, m_ready, m_err;
   int m_run;
   int m_sdiv[NCH];
   int m_sph[NCH];
   int m_left[NCH];
   bit m_en[NCH];
   bit m_tog[NCH];

   task automatic model_edge();
      bit lk, was_run, now_run, hs, bad;
      if (rst) begin
         m_p1 = 0; m_p2 = 0; m_run = 0; m_locked = 0; m_ready = 1; m_err = 0;
         for (int i = 0; i < NCH; i++) begin
            m_sdiv[i] = DD; m_sph[i] = 0; m_left[i] = 0; m_en[i] = 0; m_tog[i] = 0;
         end
         return;
      end
      lk = m_p2; m_p2 = m_p1; m_p1 = pll_locked;
      m_run = lk ? ((m_run < LC) ? m_run + 1 : LC) : 0;
      was_run = m_locked;
      now_run = (m_run >= LC);
      hs  = cfg_valid && m_ready;
      bad = (int'(cfg_ch) >= NCH) || (cfg_div >= 2 && cfg_phase >= cfg_div);
      for (int i = 0; i < NCH; i++) begin
         if (!now_run) begin
            m_en[i] = 0; m_tog[i] = 0;
         end else if (!was_run) begin
            m_tog[i]  = 0;
            m_left[i] = (m_sdiv[i] <= 1) ? 0 : m_sdiv[i] - 1 - m_sph[i];
            m_en[i]   = (m_left[i] == 0);
         end else begin
            if (m_en[i]) begin
               m_tog[i]  = !m_tog[i];
               m_left[i] = (m_sdiv[i] <= 1) ? 0 : m_sdiv[i] - 1;
            end else begin
               m_left[i] = m_left[i] - 1;
            end
            m_en[i] = (m_left[i] == 0);
         end
      end
      m_locked = now_run;
      m_err    = hs && bad;
      m_ready  = !hs;
      if (hs && !bad) begin
         m_sdiv[cfg_ch] = int'(cfg_div);
         m_sph[cfg_ch]  = int'(cfg_phase);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic [NCH-1:0] e_en, e_tog;
      for (int i = 0; i < NCH; i++) begin
         e_en[i]  = m_en[i];
         e_tog[i] = m_tog[i];
      end
      chk("locked",    32'(locked),    32'(m_locked));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      chk("cfg_err",   32'(cfg_err),   32'(m_err));
      chk("clk_en",    32'(clk_en),    32'(e_en));
      chk("clk_div",   32'(clk_div),   32'(e_tog));
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
      model_edge();
      check_outputs();
      cyc++;
      if (clk_en[1] === 1'b1) begin
         if (last_en1 >= 0) begin
            gap_last = cyc - last_en1;
            if (gap_last < gap_min) gap_min = gap_last;
         end
         last_en1 = cyc;
      end
   endtask

   // Hold a write until the model says it was taken (bounded).
   task automatic cfg_write(input int ch, input int dv, input int ph);
      bit done;
      done = 0;
      cfg_valid = 1'b1;
      cfg_ch    = 3'(ch);
      cfg_div   = DW'(dv);
      cfg_phase = DW'(ph);
      for (int k = 0; k < 4 && !done; k++) begin
         done = m_ready;
         step();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_locked(input logic val, input int maxc, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (locked !== val && n < maxc);
   endtask

   initial begin
      int n;
      rst = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      repeat (3) step();
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_ready",  32'(cfg_ready), 32'd1);
      chk("reset_en",     32'(clk_en), 32'd0);
      rst = 1'b0;
      step();

      // Back-to-back configuration (ready alternates), then two rejected writes.
      cfg_write(0, 2, 0);
      cfg_write(1, 4, 0);
      cfg_write(2, 1, 0);
      cfg_write(3, 0, 0);
      cfg_write(4, 3, 2);
      step();
      cfg_write(5, 3, 0);
      chk("err_bad_ch", 32'(cfg_err), 32'd1);
      step();
      cfg_write(1, 4, 4);
      chk("err_bad_phase", 32'(cfg_err), 32'd1);
      step();
      chk("err_clears", 32'(cfg_err), 32'd0);

      // First lock: latency and first ch0 strobe.
      pll_locked = 1'b1;
      wait_locked(1'b1, 40, n);
      chk("lock_latency", 32'(n), 32'd18);
      chk("ch0_run_cycle1", 32'(clk_en[0]), 32'd0);
      step();
      chk("ch0_run_cycle2", 32'(clk_en[0]), 32'd1);

      // Divide change on ch1 mid-period: spacing stays 4 until a wrap, then 7.
      last_en1 = -1; gap_min = 1000;
      repeat (5) step();
      cfg_write(1, 7, 0);
      repeat (25) step();
      chk("ch1_min_gap_ge4", 32'(gap_min >= 4), 32'd1);
      chk("ch1_new_gap", 32'(gap_last), 32'd7);

      for (int k = 0; k < 3; k++) begin
         step();
         chk("ch23_every_cycle", 32'(clk_en[3:2]), 32'd3);
      end

      // Lock loss: outputs quiet 3 cycles after the pin drops.
      pll_locked = 1'b0;
      wait_locked(1'b0, 10, n);
      chk("unlock_latency", 32'(n), 32'd3);
      chk("unlock_en", 32'(clk_en), 32'd0);
      chk("unlock_div", 32'(clk_div), 32'd0);

      // One-cycle glitch in QUAL restarts qualification.
      pll_locked = 1'b1;
      repeat (10) step();
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      wait_locked(1'b1, 40, n);
      chk("relock_latency", 32'(n), 32'd18);

      // Randomized traffic: config writes, lock toggles, occasional reset.
      for (int c = 0; c < 1500; c++) begin
         int r;
         r = $urandom_range(0, 999);
         rst = (r < 3);
         if (r >= 3 && r < 10) pll_locked = ~pll_locked;
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch    = 3'($urandom_range(0, 7));
         cfg_div   = DW'($urandom_range(0, 9));
         cfg_phase = DW'($urandom_range(0, 9));
         step();
      end

      // Reset while running overrides everything.
      rst = 1'b0; cfg_valid = 1'b0; pll_locked = 1'b1;
      wait_locked(1'b1, 40, n);
      chk("run_before_rst", 32'(locked), 32'd1);
      rst = 1'b1;
      step();
      chk("rst_mid_run_locked", 32'(locked), 32'd0);
      chk("rst_mid_run_en", 32'(clk_en), 32'd0);
      rst = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
